simd_shift_pipe: RTL and testbench

Parametrised SIMD shift/rotate execution pipe for the SPU even pipeline. It is the successor to the fixed-latency single-precision unit. It takes operands from the RF/FWD stage, computes halfword or word shift/rotate results, and carries each result through a configurable number of pipeline stages to write-back. It adds three things the earlier unit lacks: a programmable depth, a generic data width, and a pipeline-wide flush.

---
 rtl/simd_shift_pipe.sv | 153 +++++++++++++++
 tb/tb_simd_shift_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_shift_pipe.sv
// SIMD halfword/word shift and rotate execution pipe with programmable depth and pipeline-wide flush.
// Optional per-stage forwarding taps are built when SHIFT_PIPE_FWD_EN is defined.
module simd_shift_pipe #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      op,
    input  logic [6:0]       rt_addr,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic             reg_write,
    input  logic             flush,
    output logic [WIDTH-1:0] rt_wb,
    output logic [6:0]       rt_addr_wb,
    output logic             reg_write_wb
`ifdef SHIFT_PIPE_FWD_EN
    ,
    output logic [DEPTH*WIDTH-1:0] fwd_rt,
    output logic [DEPTH*7-1:0]     fwd_addr,
    output logic [DEPTH-1:0]       fwd_valid
`endif
);

    localparam int NWORD = WIDTH / 32;

    localparam logic [10:0] OP_SHLH  = 11'b00001011111;
    localparam logic [10:0] OP_SHL   = 11'b00001011011;
    localparam logic [10:0] OP_ROTH  = 11'b00001011100;
    localparam logic [10:0] OP_ROT   = 11'b00001011000;
    localparam logic [10:0] OP_ROTHM = 11'b00001011101;
    localparam logic [10:0] OP_ROTM  = 11'b00001011001;

    // b carries only the count bits an element operation can look at
    function automatic logic [15:0] half_op(input logic [10:0] opc, input logic [15:0] a,
                                            input logic [4:0] b);
        logic [4:0]  cnt;
        logic [31:0] dbl;
        half_op = 16'd0;
        cnt     = 5'd0;
        dbl     = 32'd0;
        case (opc)
            OP_SHLH:  half_op = (b >= 5'd16) ? 16'd0 : (a << b[3:0]);
            OP_ROTH: begin
                dbl     = {a, a} << b[3:0];
                half_op = dbl[31:16];
            end
            OP_ROTHM: begin
                cnt     = 5'd0 - b;
                half_op = (cnt >= 5'd16) ? 16'd0 : (a >> cnt[3:0]);
            end
            default:  half_op = 16'd0;
        endcase
    endfunction

    function automatic logic [31:0] word_op(input logic [10:0] opc, input logic [31:0] a,
                                            input logic [5:0] b);
        logic [5:0]  cnt;
        logic [63:0] dbl;
        word_op = 32'd0;
        cnt     = 6'd0;
        dbl     = 64'd0;
        case (opc)
            OP_SHL:   word_op = (b >= 6'd32) ? 32'd0 : (a << b[4:0]);
            OP_ROT: begin
                dbl     = {a, a} << b[4:0];
                word_op = dbl[63:32];
            end
            OP_ROTM: begin
                cnt     = 6'd0 - b;
                word_op = (cnt >= 6'd32) ? 32'd0 : (a >> cnt[4:0]);
            end
            default:  word_op = 32'd0;
        endcase
    endfunction

    logic [WIDTH-1:0] result_s;
    logic             valid_op_s;
    logic             is_half_s;
    logic             issue_valid_s;
    logic             unused_rb_s;

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [6:0]       addr_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    // Only the low count bits of each rb element matter
    assign unused_rb_s = ^rb;

    // Decode the opcode and compute the element-wise shift/rotate result
    always_comb begin
        result_s   = '0;
        valid_op_s = 1'b0;
        is_half_s  = 1'b0;
        case (op)
            OP_SHLH, OP_ROTH, OP_ROTHM: begin
                valid_op_s = 1'b1;
                is_half_s  = 1'b1;
            end
            OP_SHL, OP_ROT, OP_ROTM: begin
                valid_op_s = 1'b1;
                is_half_s  = 1'b0;
            end
            default: begin
                valid_op_s = 1'b0;
                is_half_s  = 1'b0;
            end
        endcase
        for (int w = 0; w < NWORD; w++) begin
            if (is_half_s) begin
                result_s[w*32+16 +: 16] = half_op(op, ra[w*32+16 +: 16], rb[w*32+16 +: 5]);
                result_s[w*32 +: 16]    = half_op(op, ra[w*32 +: 16], rb[w*32 +: 5]);
            end else begin
                result_s[w*32 +: 32]    = word_op(op, ra[w*32 +: 32], rb[w*32 +: 6]);
            end
        end
    end

    assign issue_valid_s = reg_write & valid_op_s & ~flush;

    // Stage registers: data and address shift every cycle, flush clears every valid bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_r[s] <= '0;
                addr_r[s] <= 7'd0;
            end
            valid_r <= '0;
        end else begin
            data_r[0] <= result_s;
            addr_r[0] <= rt_addr;
            for (int s = 1; s < DEPTH; s++) begin
                data_r[s] <= data_r[s-1];
                addr_r[s] <= addr_r[s-1];
            end
            valid_r <= {valid_r[DEPTH-2:0], issue_valid_s} & {DEPTH{~flush}};
        end
    end

    assign rt_wb        = data_r[DEPTH-1];
    assign rt_addr_wb   = addr_r[DEPTH-1];
    assign reg_write_wb = valid_r[DEPTH-1];

`ifdef SHIFT_PIPE_FWD_EN
    for (genvar s = 0; s < DEPTH; s++) begin : g_fwd
        assign fwd_rt[s*WIDTH +: WIDTH] = data_r[s];
        assign fwd_addr[s*7 +: 7]       = addr_r[s];
    end
    assign fwd_valid = valid_r;
`endif

endmodule

// File: tb/tb_simd_shift_pipe.sv
// Randomized self-checking bench for simd_shift_pipe against an element-arithmetic reference model.
// Forwarding taps are also checked when SHIFT_PIPE_FWD_EN is defined.
module tb_simd_shift_pipe;

    localparam int WIDTH = 128;
`ifdef SHIFT_PIPE_FWD_EN
    localparam int DEPTH = 6;
`else
    localparam int DEPTH = 4;
`endif

    localparam logic [10:0] SHLH  = 11'b00001011111;
    localparam logic [10:0] SHL   = 11'b00001011011;
    localparam logic [10:0] ROTH  = 11'b00001011100;
    localparam logic [10:0] ROT   = 11'b00001011000;
    localparam logic [10:0] ROTHM = 11'b00001011101;
    localparam logic [10:0] ROTM  = 11'b00001011001;
    localparam logic [10:0] NOP   = 11'd0;
    localparam logic [10:0] OP_TBL [8] = '{SHLH, SHL, ROTH, ROT, ROTHM, ROTM, NOP, 11'h7FF};

    logic             clk;
    logic             reset;
    logic [10:0]      op;
    logic [6:0]       rt_addr;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             reg_write;
    logic             flush;
    logic [WIDTH-1:0] rt_wb;
    logic [6:0]       rt_addr_wb;
    logic             reg_write_wb;
`ifdef SHIFT_PIPE_FWD_EN
    logic [DEPTH*WIDTH-1:0] fwd_rt;
    logic [DEPTH*7-1:0]     fwd_addr;
    logic [DEPTH-1:0]       fwd_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // One entry per rising edge since the last reset
    logic [WIDTH-1:0] hist_res[$];
    logic [6:0]       hist_addr[$];
    bit               hist_val[$];
    bit               hist_flush[$];

    simd_shift_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .reg_write    (reg_write),
        .flush        (flush),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb)
`ifdef SHIFT_PIPE_FWD_EN
        ,
        .fwd_rt       (fwd_rt),
        .fwd_addr     (fwd_addr),
        .fwd_valid    (fwd_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain per-element arithmetic on halfword/word values
    function automatic void ref_calc(input logic [10:0] o, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     output logic [WIDTH-1:0] r, output bit v);
        longint unsigned x, y, c, res;
        r = '0;
        v = 1'b1;
        if (o == SHLH || o == ROTH || o == ROTHM) begin
            for (int e = 0; e < WIDTH/16; e++) begin
                x = 64'(a[e*16 +: 16]);
                y = 64'(b[e*16 +: 16]);
                if (o == SHLH) begin
                    c = y & 64'd31;
                    res = (c >= 64'd16) ? 64'd0 : ((x << c) & 64'hFFFF);
                end else if (o == ROTH) begin
                    c = y & 64'd15;
                    res = ((x << c) | (x >> (64'd16 - c))) & 64'hFFFF;
                end else begin
                    c = (64'd0 - y) & 64'd31;
                    res = (c >= 64'd16) ? 64'd0 : (x >> c);
                end
                r[e*16 +: 16] = res[15:0];
            end
        end else if (o == SHL || o == ROT || o == ROTM) begin
            for (int e = 0; e < WIDTH/32; e++) begin
                x = 64'(a[e*32 +: 32]);
                y = 64'(b[e*32 +: 32]);
                if (o == SHL) begin
                    c = y & 64'd63;
                    res = (c >= 64'd32) ? 64'd0 : ((x << c) & 64'hFFFF_FFFF);
                end else if (o == ROT) begin
                    c = y & 64'd31;
                    res = ((x << c) | (x >> (64'd32 - c))) & 64'hFFFF_FFFF;
                end else begin
                    c = (64'd0 - y) & 64'd63;
                    res = (c >= 64'd32) ? 64'd0 : (x >> c);
                end
                r[e*32 +: 32] = res[31:0];
            end
        end else begin
            v = 1'b0;
        end
    endfunction

    // Expected content of stage s: the instruction issued s-1 edges ago, killed by any flush since
    function automatic void exp_stage(input int s, output logic [WIDTH-1:0] d,
                                      output logic [6:0] ad, output bit v);
        int n;
        int idx;
        n   = hist_res.size() - 1;
        idx = n - s + 1;
        d = '0;
        ad = 7'd0;
        v = 1'b0;
        if (idx >= 0) begin
            d  = hist_res[idx];
            ad = hist_addr[idx];
            v  = hist_val[idx];
            for (int j = idx; j <= n; j++) begin
                if (hist_flush[j]) v = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        logic [WIDTH-1:0] d;
        logic [6:0]       ad;
        bit               v;
        exp_stage(DEPTH, d, ad, v);
        check_val("wb_data", rt_wb, d);
        check_val("wb_addr", 128'(rt_addr_wb), 128'(ad));
        check_val("wb_valid", 128'(reg_write_wb), 128'(v));
`ifdef SHIFT_PIPE_FWD_EN
        for (int s = 1; s <= DEPTH; s++) begin
            exp_stage(s, d, ad, v);
            check_val("fwd_rt", fwd_rt[(s-1)*WIDTH +: WIDTH], d);
            check_val("fwd_addr", 128'(fwd_addr[(s-1)*7 +: 7]), 128'(ad));
            check_val("fwd_valid", 128'(fwd_valid[s-1]), 128'(v));
        end
`endif
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_data"}, rt_wb, '0);
        check_val({tag, "_addr"}, 128'(rt_addr_wb), 128'd0);
        check_val({tag, "_valid"}, 128'(reg_write_wb), 128'd0);
`ifdef SHIFT_PIPE_FWD_EN
        check_val({tag, "_fwd_valid"}, 128'(fwd_valid), 128'd0);
        check_val({tag, "_fwd_addr"}, 128'(fwd_addr), 128'd0);
        check_val({tag, "_fwd_rt_or"}, 128'(|fwd_rt), 128'd0);
`endif
    endtask

    // Drive one issue cycle, advance one edge, then compare against the model
    task automatic step(input logic [10:0] o, input logic [6:0] ad, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit rw, input bit fl);
        logic [WIDTH-1:0] r;
        bit               v;
        op = o;
        rt_addr = ad;
        ra = a;
        rb = b;
        reg_write = rw;
        flush = fl;
        ref_calc(o, a, b, r, v);
        @(posedge clk);
        hist_res.push_back(r);
        hist_addr.push_back(ad);
        hist_val.push_back(rw && v);
        hist_flush.push_back(fl);
        @(negedge clk);
        check_all();
    endtask

    task automatic nop_step();
        step(NOP, 7'd0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_vec();
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH/32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Single issue followed by draining nops; checks the constant result at write-back
    task automatic directed(input string tag, input logic [10:0] o, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [6:0] ad,
                            input logic [WIDTH-1:0] exp);
        logic [127:0] oh;
        step(o, ad, a, b, 1'b1, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
`ifdef SHIFT_PIPE_FWD_EN
            oh = 128'd1 << (i - 1);
            check_val({tag, "_onehot"}, 128'(fwd_valid), oh);
            check_val({tag, "_fwdaddr"}, 128'(fwd_addr[(i-1)*7 +: 7]), 128'(ad));
`endif
            nop_step();
        end
        oh = 128'd1 << (DEPTH - 1);
`ifdef SHIFT_PIPE_FWD_EN
        check_val({tag, "_onehot"}, 128'(fwd_valid), oh);
`endif
        check_val(tag, rt_wb, exp);
        check_val({tag, "_addr"}, 128'(rt_addr_wb), 128'(ad));
        check_val({tag, "_valid"}, 128'(reg_write_wb), 128'd1);
    endtask

    // shlh, nop, shl back to back; optional flush during the third issue cycle
    task automatic b2b(input string tag, input bit fl);
        step(SHLH, 7'd5, rnd_vec(), rnd_vec(), 1'b1, 1'b0);
        step(NOP, 7'd9, rnd_vec(), rnd_vec(), 1'b1, 1'b0);
        step(SHL, 7'd14, rnd_vec(), rnd_vec(), 1'b1, fl);
        repeat (DEPTH - 3) nop_step();
        check_val({tag, "_v0"}, 128'(reg_write_wb), fl ? 128'd0 : 128'd1);
        check_val({tag, "_a0"}, 128'(rt_addr_wb), 128'd5);
        nop_step();
        check_val({tag, "_v1"}, 128'(reg_write_wb), 128'd0);
        nop_step();
        check_val({tag, "_v2"}, 128'(reg_write_wb), fl ? 128'd0 : 128'd1);
        check_val({tag, "_a2"}, 128'(rt_addr_wb), 128'd14);
        repeat (2) nop_step();
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(OP_TBL[$urandom_range(0, 7)], 7'($urandom), rnd_vec(), rnd_vec(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        reset = 1'b1;
        op = NOP;
        rt_addr = 7'd0;
        ra = '0;
        rb = '0;
        reg_write = 1'b0;
        flush = 1'b0;
        #2;
        check_zero("reset");
        #8;
        check_zero("reset_hold");
        #1;
        reset = 1'b0;

        directed("shlh", SHLH, {8{16'h8001}}, {8{16'h0001}}, 7'd3, {8{16'h0002}});
        directed("shlh_limit", SHLH, {8{16'h8001}}, {8{16'h0010}}, 7'd4, '0);
        directed("rot", ROT, {4{32'h8000_0001}}, {4{32'h0000_0001}}, 7'd7, {4{32'h0000_0003}});
        directed("rotm", ROTM, {4{32'h8000_0000}}, {4{32'hFFFF_FFFC}}, 7'd21,
                 {4{32'h0800_0000}});
        repeat (DEPTH) nop_step();

        b2b("b2b", 1'b0);
        b2b("b2b_flush", 1'b1);

        random_run(300);

        // Asynchronous reset mid-stream must clear everything before any edge
        reset = 1'b1;
        #1;
        check_zero("midreset");
        hist_res.delete();
        hist_addr.delete();
        hist_val.delete();
        hist_flush.delete();
        #1;
        reset = 1'b0;

        random_run(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
